// File: rtl/tri_bus_rx.sv
// tri_bus_rx: deserializes LSB-first frames from a tri-state bus line.
// Optional even-parity bit checking is enabled by defining TRI_RX_PARITY_EN.
module tri_bus_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_d,
    input  logic             bus_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
`ifdef TRI_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

`ifdef TRI_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t state, state_nxt;

    logic [WIDTH-1:0] shreg, sh_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last_bit;
    logic             done;
    logic             fe_nxt;
`ifdef TRI_RX_PARITY_EN
    logic             pe_nxt;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, next shift contents and completion/error decode
    always_comb begin
        state_nxt = state;
        sh_nxt    = shreg;
        cnt_nxt   = '0;
        done      = 1'b0;
        fe_nxt    = 1'b0;
`ifdef TRI_RX_PARITY_EN
        pe_nxt    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus_en) begin
                    sh_nxt    = '0;
                    sh_nxt[0] = bus_d;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus_en) begin
                    sh_nxt[cnt[IW-1:0]] = bus_d;
                    cnt_nxt = cnt + CW'(1);
                    if (last_bit) begin
`ifdef TRI_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        done      = 1'b1;
                        state_nxt = GAP;
`endif
                    end
                end else begin
                    fe_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef TRI_RX_PARITY_EN
            PARITY: begin
                if (bus_en) begin
                    if (^{shreg, bus_d}) pe_nxt = 1'b1;
                    else                 done   = 1'b1;
                    state_nxt = GAP;
                end else begin
                    fe_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            GAP: begin
                if (!bus_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, output word, handshake and one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef TRI_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            shreg      <= sh_nxt;
            cnt        <= cnt_nxt;
            frame_err  <= fe_nxt;
            overrun    <= 1'b0;
`ifdef TRI_RX_PARITY_EN
            parity_err <= pe_nxt;
`endif
            if (done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= sh_nxt;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
